// File: rtl/mode_reg_reader.sv
// Mode register read-back: tracks a shadow of the writer's bits and
// streams a snapshot as one addressed bit or a 16-beat LSB-first scan.
module mode_reg_reader #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] register,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic             wr_strobe,
  input  logic             rd_req,
  input  logic             rd_scan,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic             rd_bit,
  output logic [SEL_W-1:0] rd_index,
  output logic             busy,
  output logic [WIDTH-1:0] shadow
);

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    SCAN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] snap;
  logic [WIDTH-1:0] shadow_nxt;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] wr_bit;
  logic             accept;
  logic             last_beat;

  // Selects 12..15 all land on bit 15 (writer's default arm).
  function automatic logic [SEL_W-1:0] bit_of(
    input logic [SEL_W-1:0] s
  );
    return (s >= SEL_W'(12)) ? SEL_W'(15) : s;
  endfunction

  always_comb begin
    wr_bit     = bit_of(wr_sel);
    shadow_nxt = shadow;
    if (wr_strobe)
      shadow_nxt[wr_bit] = register[wr_bit];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else
      shadow <= shadow_nxt;
  end

  assign busy      = (state != IDLE);
  assign rd_valid  = busy;
  assign accept    = rd_valid && rd_ready;
  assign last_beat = (idx == SEL_W'(15));
  assign rd_bit    = busy ? snap[idx] : 1'b0;
  assign rd_index  = busy ? idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      snap  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            snap <= shadow_nxt;
            if (rd_scan) begin
              idx   <= '0;
              state <= SCAN;
            end else begin
              idx   <= rd_sel;
              state <= SINGLE;
            end
          end
        end
        SINGLE: begin
          if (accept)
            state <= IDLE;
        end
        SCAN: begin
          if (accept) begin
            if (last_beat)
              state <= IDLE;
            else
              idx <= idx + SEL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mode_reg_reader.sv
// Scoreboard bench for mode_reg_reader: directed writes, single reads,
// scans, snapshot isolation, collision and mid-scan reset.
module tb_mode_reg_reader;

  logic        clk;
  logic        rst_n;
  logic [15:0] register;
  logic [3:0]  wr_sel;
  logic        wr_strobe;
  logic        rd_req;
  logic        rd_scan;
  logic [3:0]  rd_sel;
  logic        rd_ready;
  logic        rd_valid;
  logic        rd_bit;
  logic [3:0]  rd_index;
  logic        busy;
  logic [15:0] shadow;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  mode_reg_reader #(.WIDTH(16), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .register(register), .wr_sel(wr_sel),
    .wr_strobe(wr_strobe), .rd_req(rd_req),
    .rd_scan(rd_scan), .rd_sel(rd_sel),
    .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_bit(rd_bit), .rd_index(rd_index),
    .busy(busy), .shadow(shadow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a beat is accepted at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat: unexpected idx=%0d bit=%0d",
                 rd_index, rd_bit);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({rd_index, rd_bit} !== e) begin
          n_err++;
          $display("FAIL beat: got idx=%0d bit=%0d expected idx=%0d bit=%0d",
                   rd_index, rd_bit, e[4:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bit(input logic [3:0] s, input logic v);
    logic [3:0] b;
    b = (s >= 4'd12) ? 4'd15 : s;
    register    = '0;
    register[b] = v;
    wr_sel      = s;
    wr_strobe   = 1'b1;
    tick();
    wr_strobe   = 1'b0;
    register    = '0;
  endtask

  task automatic write_mode(input logic [15:0] v);
    for (int s = 0; s < 12; s++)
      write_bit(4'(s), v[s]);
    write_bit(4'd12, v[15]);
  endtask

  task automatic push_scan(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({4'(i), v[i]});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    register  = '0;
    wr_sel    = '0;
    wr_strobe = 1'b0;
    rd_req    = 1'b0;
    rd_scan   = 1'b0;
    rd_sel    = '0;
    rd_ready  = 1'b0;
    tick();
    tick();
    check("rst_valid", {15'd0, rd_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_index", {12'd0, rd_index}, 16'd0);
    check("rst_bit", {15'd0, rd_bit}, 16'd0);
    check("rst_shadow", shadow, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Writes, incl. select 13 landing on bit 15
    write_bit(4'd3, 1'b1);
    check("shadow_lag", shadow, 16'h0008);
    write_bit(4'd13, 1'b1);
    check("shadow_8008", shadow, 16'h8008);
    check("shadow_b13", {15'd0, shadow[13]}, 16'd0);

    // Single read with back-pressure
    rd_ready = 1'b0;
    rd_req   = 1'b1;
    rd_scan  = 1'b0;
    rd_sel   = 4'd3;
    exp_q.push_back({4'd3, 1'b1});
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {15'd0, rd_valid}, 16'd1);
      check("bp_bit", {15'd0, rd_bit}, 16'd1);
      check("bp_index", {12'd0, rd_index}, 16'd3);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    check("single_done", {15'd0, busy}, 16'd0);
    check("single_valid", {15'd0, rd_valid}, 16'd0);

    // Full scan; bit 13 is unwritable so A5C3 becomes 85C3
    write_mode(16'h85C3);
    check("shadow_85c3", shadow, 16'h85C3);
    rd_req  = 1'b1;
    rd_scan = 1'b1;
    push_scan(16'h85C3, 16);
    tick();
    rd_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        check("scan_busy", {15'd0, busy}, 16'd1);
        if (k == 15) rd_req = 1'b1;
      end else begin
        rd_req = 1'b0;
        check("scan_end", {15'd0, busy}, 16'd0);
      end
    end
    tick();
    check("rereq_ignored", {15'd0, busy}, 16'd0);

    // Snapshot isolation
    write_mode(16'h0000);
    check("shadow_zero", shadow, 16'h0000);
    rd_req  = 1'b1;
    rd_scan = 1'b1;
    push_scan(16'h0000, 16);
    tick();
    rd_req = 1'b0;
    repeat (5) tick();
    check("iso_beat5", {12'd0, rd_index}, 16'd5);
    write_bit(4'd0, 1'b1);
    wait_idle(40);
    check("iso_shadow", shadow, 16'h0001);

    // Write/request collision and ignored second request
    register  = 16'h0080;
    wr_sel    = 4'd7;
    wr_strobe = 1'b1;
    rd_req    = 1'b1;
    rd_scan   = 1'b0;
    rd_sel    = 4'd7;
    rd_ready  = 1'b0;
    exp_q.push_back({4'd7, 1'b1});
    tick();
    wr_strobe = 1'b0;
    register  = '0;
    rd_sel    = 4'd2;
    tick();
    rd_ready = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    check("coll_idle", {15'd0, busy}, 16'd0);
    check("coll_shadow", shadow, 16'h0081);

    // Reset mid-scan at beat 8
    rd_req  = 1'b1;
    rd_scan = 1'b1;
    push_scan(16'h0081, 8);
    tick();
    rd_req = 1'b0;
    repeat (8) tick();
    check("pre_rst_idx", {12'd0, rd_index}, 16'd8);
    rst_n = 1'b0;
    #1;
    check("mid_valid", {15'd0, rd_valid}, 16'd0);
    check("mid_busy", {15'd0, busy}, 16'd0);
    check("mid_index", {12'd0, rd_index}, 16'd0);
    check("mid_shadow", shadow, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    rd_req  = 1'b1;
    rd_scan = 1'b1;
    push_scan(16'h0000, 16);
    tick();
    rd_req = 1'b0;
    check("rescan_idx0", {12'd0, rd_index}, 16'd0);
    wait_idle(40);
    tick();
    check("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
